// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnn_pkg
// Purpose  : Shared CNN datapath constants, pool2 scheduler defaults and the
//            pool2 scheduler state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    // conv2 row geometry
    localparam int DATA_W = 224;
    localparam int ROWS   = 4;

    // pool2 scheduler defaults
    localparam int POOL2_LEAD   = 16;
    localparam int POOL2_STRIDE = 3;
    localparam int POOL2_GROUPS = 4;

    // Scheduler states, explicitly encoded
    typedef enum logic [1:0] {
        ST_SKIP  = 2'd0,
        ST_CAPT  = 2'd1,
        ST_ISSUE = 2'd2
    } pool2_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pool2_rowbuf.sv
`default_nettype none
// ============================================================================
// Module   : pool2_rowbuf
// Purpose  : Bank of ROWS x DATA_W row registers with a single indexed write
//            port; all rows are visible in parallel.
// Revision : 1.0 - initial release
// ============================================================================
module pool2_rowbuf #(
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int ROWS   = cnn_pkg::ROWS,
    parameter int IDX_W  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [IDX_W-1:0]             widx,
    input  logic [DATA_W-1:0]            wdata,
    output logic [ROWS-1:0][DATA_W-1:0]  rows
);

    import cnn_pkg::*;

    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            logic [DATA_W-1:0] r_q;

            // Row gi loads only when it is the addressed row; otherwise it holds
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_q <= '0;
                end else if (we && (widx == IDX_W'(gi))) begin
                    r_q <= wdata;
                end
            end

            assign rows[gi] = r_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/pool2_sched.sv
`default_nettype none
// ============================================================================
// Module   : pool2_sched
// Purpose  : Selects rows from the conv2 beat stream (skip LEAD beats, then
//            capture ROWS rows STRIDE beats apart) and presents them as one
//            window to pool2 with a valid/ready handoff; tracks group index.
// Revision : 1.0 - initial release
// ============================================================================
module pool2_sched #(
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int ROWS   = cnn_pkg::ROWS,
    parameter int LEAD   = cnn_pkg::POOL2_LEAD,
    parameter int STRIDE = cnn_pkg::POOL2_STRIDE,
    parameter int GROUPS = cnn_pkg::POOL2_GROUPS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  conv_valid,
    input  logic [DATA_W-1:0]     conv_data,
    output logic                  conv_ready,
    output logic                  pool_valid,
    input  logic                  pool_ready,
    output logic [DATA_W-1:0]     pool_row0,
    output logic [DATA_W-1:0]     pool_row1,
    output logic [DATA_W-1:0]     pool_row2,
    output logic [DATA_W-1:0]     pool_row3,
    output logic [((GROUPS > 1) ? $clog2(GROUPS) : 1)-1:0] group_idx,
    output logic                  frame_done
);

    import cnn_pkg::*;

    localparam int c_cnt_w = $clog2(max_int(LEAD, STRIDE) + 1);
    localparam int c_row_w = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int c_grp_w = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    localparam logic [c_cnt_w-1:0] c_lead_last   = c_cnt_w'((LEAD > 0) ? LEAD - 1 : 0);
    localparam logic [c_cnt_w-1:0] c_stride_last = c_cnt_w'(STRIDE - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_post    = c_cnt_w'((STRIDE > 1) ? 1 : 0);
    localparam logic [c_row_w-1:0] c_row_last    = c_row_w'(ROWS - 1);
    localparam logic [c_grp_w-1:0] c_grp_last    = c_grp_w'(GROUPS - 1);
    localparam bit                 c_no_lead     = (LEAD == 0);

    pool2_state_e         r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_row_w-1:0]   r_row;
    logic [c_grp_w-1:0]   r_grp;
    logic                 r_pool_valid;
    logic                 r_frame_done;

    logic                         w_beat;
    logic                         w_capt_phase;
    logic                         w_capture;
    logic                         w_handoff;
    logic [ROWS-1:0][DATA_W-1:0]  w_rows;

    // Ready is a pure state decode so it never depends on the current inputs
    assign conv_ready = (r_state != ST_ISSUE);

    // With no lead-in the skip state already behaves as the capture state
    assign w_beat       = conv_valid & conv_ready;
    assign w_capt_phase = (r_state == ST_CAPT) || ((r_state == ST_SKIP) && c_no_lead);
    assign w_capture    = w_beat && w_capt_phase && (r_cnt == '0);
    assign w_handoff    = r_pool_valid & pool_ready;

    // Scheduler FSM: beat counting, row indexing, window issue and group tracking
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_SKIP;
            r_cnt        <= '0;
            r_row        <= '0;
            r_grp        <= '0;
            r_pool_valid <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_SKIP, ST_CAPT: begin
                    if (w_beat) begin
                        if (w_capt_phase) begin
                            if (w_capture) begin
                                if (r_row == c_row_last) begin
                                    r_state      <= ST_ISSUE;
                                    r_pool_valid <= 1'b1;
                                    r_cnt        <= '0;
                                    r_row        <= '0;
                                end else begin
                                    r_state <= ST_CAPT;
                                    r_row   <= r_row + 1'b1;
                                    r_cnt   <= c_cnt_post;
                                end
                            end else begin
                                // Dropping beats between captured rows
                                r_cnt <= (r_cnt == c_stride_last) ? '0 : r_cnt + 1'b1;
                            end
                        end else begin
                            // Dropping the lead-in beats of the group
                            if (r_cnt == c_lead_last) begin
                                r_cnt   <= '0;
                                r_state <= ST_CAPT;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                end
                ST_ISSUE: begin
                    if (w_handoff) begin
                        r_state      <= ST_SKIP;
                        r_pool_valid <= 1'b0;
                        r_cnt        <= '0;
                        r_grp        <= (r_grp == c_grp_last) ? '0 : r_grp + 1'b1;
                        r_frame_done <= (r_grp == c_grp_last);
                    end
                end
                default: begin
                    r_state      <= ST_SKIP;
                    r_pool_valid <= 1'b0;
                    r_cnt        <= '0;
                    r_row        <= '0;
                end
            endcase
        end
    end

    pool2_rowbuf #(
        .DATA_W (DATA_W),
        .ROWS   (ROWS),
        .IDX_W  (c_row_w)
    ) u_rowbuf (
        .clk    (clk),
        .rst    (rst),
        .we     (w_capture),
        .widx   (r_row),
        .wdata  (conv_data),
        .rows   (w_rows)
    );

    assign pool_row0  = w_rows[0];
    assign pool_row1  = w_rows[1];
    assign pool_row2  = w_rows[2];
    assign pool_row3  = w_rows[3];
    assign pool_valid = r_pool_valid;
    assign group_idx  = r_grp;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: doc/pool2_sched.md
POOL2_SCHED -- requirements
Module: pool2_sched

Interface
REQ-001 SHALL have parameters: DATA_W, 224, conv2 row width in bits; ROWS, 4, rows per pooling group; LEAD, 16, beats dropped before the first row of each group; STRIDE, 3, beat spacing between captured rows (>=1); GROUPS, 4, groups per frame.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 rst  in  1  reset; synchronous and active-low (reset when rst==0 at a clk edge).
REQ-004 conv_valid  in  1  conv2 row beat present.
REQ-005 conv_data  in  DATA_W  conv2 row data.
REQ-006 conv_ready  out  1  block accepts a conv2 beat.
REQ-007 pool_valid  out  1  four-row window ready for pool2.
REQ-008 pool_ready  in  1  pool2 accepts the window.
REQ-009 pool_row0..pool_row3  out  DATA_W each  captured rows, in capture order.
REQ-010 group_idx  out  clog2(GROUPS)  index of the group currently presented or being filled.
REQ-011 frame_done  out  1  one-cycle pulse on handoff of the last group.

Function
REQ-012 Beat SHALL mean conv_valid & conv_ready at a clk edge; all counting SHALL be in beats, never in raw cycles.
REQ-013 FSM SHALL have states SKIP, CAPT, ISSUE; reset state SKIP.
REQ-014 SKIP: drop LEAD beats, then go to CAPT; if LEAD==0, enter CAPT directly.
REQ-015 CAPT: capture the first beat into row k (k = 0..ROWS-1), then drop STRIDE-1 beats before each subsequent capture.
REQ-016 Capture SHALL register conv_data on the beat edge; non-captured rows SHALL hold their value.
REQ-017 After the ROWS-th capture, the state SHALL go to ISSUE; pool_valid SHALL assert on the next cycle (latency 1 cycle from the last capture beat).
REQ-018 conv_ready SHALL be 1 in SKIP and CAPT and 0 in ISSUE, decoded from state only with no input dependency.
REQ-019 In ISSUE, pool_valid SHALL stay high and pool_row0..3 stable until pool_valid & pool_ready.
REQ-020 On handoff, the next state SHALL be SKIP, pool_valid 0 and the beat counter 0 on the following cycle.
REQ-021 On handoff, group_idx SHALL increment, wrapping GROUPS-1 -> 0; frame_done SHALL pulse high for the cycle after the handoff of group GROUPS-1 only.
REQ-022 pool_ready high before pool_valid rises SHALL allow handoff in the first ISSUE cycle.
REQ-023 conv_data SHALL be ignored when conv_valid==0 or conv_ready==0.
REQ-024 The beat counter SHALL be clog2(max(LEAD,STRIDE)+1) bits wide and SHALL never overflow.

Reset
REQ-025 When rst==0, the block SHALL set state=SKIP, counters=0, row index=0, pool_row0..3=0, pool_valid=0, frame_done=0, group_idx=0.
REQ-026 Reset mid-group or during ISSUE SHALL discard partial rows and any pending window; no pool_valid SHALL follow.
REQ-027 conv_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-028 Shared package cnn_pkg SHALL hold DATA_W, ROWS, the pool2 default LEAD, STRIDE and GROUPS values, and the FSM state enum.
REQ-029 The row bank SHALL be one sub-module, pool2_rowbuf: ROWS x DATA_W registers with write-enable and write index; FSM and counters stay in pool2_sched.

Verification
REQ-030 Defaults, conv_valid held 1, conv_data=beat number: beats 0-15 dropped; rows = 16, 19, 22, 25; pool_valid high the cycle after beat 25.
REQ-031 pool_ready low 5 cycles after pool_valid rises: conv_ready=0 and rows unchanged throughout; handoff on the cycle pool_ready=1; conv_ready=1 on the next cycle.
REQ-032 conv_valid toggling 1/0: rows still = beats 16, 19, 22, 25; captures land only on valid cycles.
REQ-033 rst=0 for one cycle after row1 is captured: rows read 0, no pool_valid; the next window captures beats 16, 19, 22, 25 counted from reset release.
REQ-034 Four back-to-back groups with pool_ready=1: group_idx steps 0, 1, 2, 3, 0; frame_done pulses once, after the 4th handoff.
REQ-035 LEAD=0, STRIDE=1: rows = beats 0, 1, 2, 3; pool_valid high the cycle after beat 3.
